sram_bridge_ctrl: RTL and testbench

//  Parametrised controller for an external asynchronous SRAM (IS61WV-class).

---
 rtl/sram_bridge_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sram_bridge_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge_ctrl.sv
// sram_bridge_ctrl: bridges one core load/store at a time onto an external
// asynchronous SRAM. Each access is split into MEM_W-wide beats, each beat
// running SETUP -> ACCESS (WAIT_CYC cycles) -> RECOVER. Every SRAM pin is
// driven from a flop, so the strobes are computed from the next state.
module sram_bridge_ctrl #(
    parameter int          BUS_W     = 64,
    parameter int          MEM_W     = 16,
    parameter int          ADDR_W    = 19,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          WAIT_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic [63:0]        req_addr,
    input  logic [BUS_W-1:0]   req_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [BUS_W-1:0]   rsp_rdata,
    output logic               busy,
    inout  wire  [MEM_W-1:0]   sram_dq,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [MEM_W/8-1:0] sram_be_n
);
    localparam int          MB        = MEM_W / 8;          // bytes per SRAM word
    localparam int          MB_LOG    = $clog2(MB);
    localparam int          NB_MAX    = BUS_W / MEM_W;      // beats in a full-width access
    localparam logic [63:0] MEM_BYTES = (64'd1 << ADDR_W) * 64'(MB);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RECOVER, RESP} state_t;

    state_t             state, state_d;

    // captured request
    logic               we_r;
    logic [1:0]         size_r;
    logic [1:0]         lane_r;
    logic [BUS_W-1:0]   wdata_r;
    logic               err_r;
    logic [3:0]         nb_m1_r;
    logic [3:0]         beat_r;
    logic [3:0]         wait_cnt;
    logic [BUS_W-1:0]   rdata_acc;

    // pin-side registers and next values
    logic [MEM_W-1:0]   dq_out;
    logic               dq_oe;
    logic               active_d;
    logic [MB-1:0]      be_pat;

    // request decode
    logic               handshake;
    logic               req_err;
    logic [63:0]        req_off;
    logic [1:0]         req_lane;
    logic [3:0]         req_nb_m1;

    // Active-low lane enables: all lanes for word-or-wider accesses, else only the addressed ones.
    function automatic logic [MB-1:0] be_of(input logic [1:0] size, input logic [1:0] lane);
        logic [MB-1:0] be;
        int            nbytes;
        nbytes = 1 << size;
        be     = '0;
        if (nbytes < MB) begin
            for (int i = 0; i < MB; i++)
                be[i] = !(i >= int'(lane) && i < int'(lane) + nbytes);
        end
        return be;
    endfunction

    // Store data for one beat: a slice of the core word, or the sub-word replicated across lanes.
    function automatic logic [MEM_W-1:0] beat_dq(input logic [BUS_W-1:0] wdata,
                                                 input logic [1:0] size, input logic [3:0] beat);
        logic [MEM_W-1:0] d;
        int               nbytes;
        nbytes = 1 << size;
        d      = '0;
        if (nbytes >= MB) begin
            for (int k = 0; k < NB_MAX; k++)
                if (int'(beat) == k) d = wdata[k*MEM_W +: MEM_W];
        end else begin
            for (int i = 0; i < MB; i++)
                d[i*8 +: 8] = wdata[(i % nbytes)*8 +: 8];
        end
        return d;
    endfunction

    // Load data for one beat: sub-word reads are shifted down to bit 0 and zero-extended.
    function automatic logic [MEM_W-1:0] load_beat(input logic [MEM_W-1:0] dq,
                                                   input logic [1:0] size, input logic [1:0] lane);
        logic [MEM_W-1:0] d;
        int               nbytes;
        nbytes = 1 << size;
        d      = dq;
        if (nbytes < MB) begin
            d = dq >> (8 * int'(lane));
            for (int i = 0; i < MB; i++)
                if (i >= nbytes) d[i*8 +: 8] = 8'h00;
        end
        return d;
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign handshake = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && err_r;
    assign rsp_rdata = (rsp_valid && !err_r) ? rdata_acc : '0;
    assign sram_dq   = dq_oe ? dq_out : {MEM_W{1'bz}};

    // Decode the incoming request: error conditions, first lane and beat count.
    always_comb begin
        req_off   = req_addr - BASE_ADDR;
        req_lane  = req_addr[1:0] & 2'(MB - 1);
        req_err   = ((req_addr & ((64'd1 << req_size) - 64'd1)) != 64'd0)
                 || (req_addr < BASE_ADDR) || (req_off >= MEM_BYTES)
                 || ((8 << req_size) > BUS_W);
        req_nb_m1 = 4'd0;
        if ((1 << req_size) >= MB) req_nb_m1 = 4'(((1 << req_size) / MB) - 1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic plus the next values of the registered strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a variable unassigned (no latch).
        state_d  = state;
        active_d = 1'b0;
        be_pat   = be_of(size_r, lane_r);
        unique case (state)
            IDLE:    if (handshake) state_d = req_err ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (wait_cnt == WAIT_LAST) state_d = RECOVER;
            RECOVER: state_d = (beat_r == nb_m1_r) ? RESP : SETUP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state == IDLE) be_pat = be_of(req_size, req_lane);
        active_d = (state_d == SETUP) || (state_d == ACCESS) || (state_d == RECOVER);
    end

    // Request capture, beat/wait counters, address and store-data pins, load assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r      <= 1'b0;
            size_r    <= 2'd0;
            lane_r    <= 2'd0;
            wdata_r   <= '0;
            err_r     <= 1'b0;
            nb_m1_r   <= 4'd0;
            beat_r    <= 4'd0;
            wait_cnt  <= 4'd0;
            rdata_acc <= '0;
            sram_addr <= '0;
            dq_out    <= '0;
        end else begin
            if (handshake) begin
                we_r      <= req_we;
                size_r    <= req_size;
                lane_r    <= req_lane;
                wdata_r   <= req_wdata;
                err_r     <= req_err;
                nb_m1_r   <= req_nb_m1;
                beat_r    <= 4'd0;
                rdata_acc <= '0;
                if (!req_err) begin
                    sram_addr <= req_off[MB_LOG +: ADDR_W];
                    dq_out    <= beat_dq(req_wdata, req_size, 4'd0);
                end
            end
            if (state == SETUP)       wait_cnt <= 4'd0;
            else if (state == ACCESS) wait_cnt <= wait_cnt + 4'd1;
            // Read data is taken on the last cycle with oe_n low.
            if (state == ACCESS && wait_cnt == WAIT_LAST && !we_r) begin
                for (int k = 0; k < NB_MAX; k++)
                    if (beat_r == 4'(k)) rdata_acc[k*MEM_W +: MEM_W] <= load_beat(sram_dq, size_r, lane_r);
            end
            if (state == RECOVER && state_d == SETUP) begin
                beat_r    <= beat_r + 4'd1;
                sram_addr <= sram_addr + ADDR_W'(1);
                dq_out    <= beat_dq(wdata_r, size_r, beat_r + 4'd1);
            end
        end
    end

    // Strobe pins registered from the next state; reset releases them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
            dq_oe     <= 1'b0;
        end else begin
            sram_ce_n <= !active_d;
            sram_oe_n <= !(state_d == ACCESS && !we_r);
            sram_we_n <= !(state_d == ACCESS && we_r);
            sram_be_n <= active_d ? be_pat : '1;
            dq_oe     <= (state_d == ACCESS || state_d == RECOVER) && we_r;
        end
    end

endmodule

// File: tb/tb_sram_bridge_ctrl.sv
// tb_sram_bridge_ctrl: directed and random load/store traffic against a
// pin-level SRAM device model and a byte-addressed transaction reference.
module tb_sram_bridge_ctrl;
    localparam int          BUS_W     = 64;
    localparam int          MEM_W     = 16;
    localparam int          ADDR_W    = 19;
    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam logic [63:0] MEM_BYTES = 64'd1 << 20;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       dq;
        logic [1:0]        be_n;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              req_valid, req_valid3;
    logic              req_ready, req_ready3;
    logic              req_we;
    logic [1:0]        req_size;
    logic [63:0]       req_addr;
    logic [BUS_W-1:0]  req_wdata;
    logic              rsp_valid, rsp_valid3, rsp_err, rsp_err3, busy, busy3;
    logic [BUS_W-1:0]  rsp_rdata, rsp_rdata3;
    wire  [15:0]       sram_dq, sram_dq3;
    logic [ADDR_W-1:0] sram_addr, sram_addr3;
    logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ce_n3, sram_oe_n3, sram_we_n3;
    logic [1:0]        sram_be_n, sram_be_n3;

    sram_bridge_ctrl #(.WAIT_CYC(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_bridge_ctrl #(.WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
        .rsp_err(rsp_err3), .rsp_rdata(rsp_rdata3), .busy(busy3), .sram_dq(sram_dq3),
        .sram_addr(sram_addr3), .sram_ce_n(sram_ce_n3), .sram_oe_n(sram_oe_n3),
        .sram_we_n(sram_we_n3), .sram_be_n(sram_be_n3)
    );

    // SRAM device model (pins) and byte-level reference memory (transactions)
    logic [15:0] dev     [0:(1<<ADDR_W)-1];
    logic [7:0]  ref_mem [0:(1<<20)-1];

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? dev[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n)
            for (int i = 0; i < 2; i++)
                if (!sram_be_n[i]) dev[sram_addr][i*8 +: 8] = sram_dq[i*8 +: 8];
    end

    int    n_checks = 0, n_pass = 0;
    int    ce_cycles = 0, overlap_cnt = 0, rsp_seen = 0;
    logic  we_prev = 1'b1;
    beat_t beat_q[$];

    // Pin monitor: chip-enable activity, strobe overlap, one record per write strobe.
    always @(negedge clk) begin
        if (!sram_ce_n) ce_cycles++;
        if (!sram_oe_n && !sram_we_n) overlap_cnt++;
        if (rsp_valid) rsp_seen++;
        if (!sram_we_n && we_prev) beat_q.push_back('{sram_addr, sram_dq, sram_be_n});
        we_prev = sram_we_n;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Transaction-level reference: error rule, latency rule, byte-addressed memory.
    task automatic model(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, input int wait_cyc,
                         output logic err, output logic [63:0] rdata, output int lat);
        int nbytes, nb, off;
        nbytes = 1 << size;
        nb     = (nbytes / 2 > 1) ? nbytes / 2 : 1;
        err    = ((addr % 64'(nbytes)) != 64'd0) || (addr < BASE) ||
                 ((addr - BASE) >= MEM_BYTES) || (8 * nbytes > BUS_W);
        lat    = err ? 1 : nb * (wait_cyc + 2) + 1;
        rdata  = '0;
        if (!err) begin
            off = int'(addr - BASE);
            for (int b = 0; b < nbytes; b++) begin
                if (we) ref_mem[off + b] = wdata[8*b +: 8];
                else    rdata[8*b +: 8] = ref_mem[off + b];
            end
        end
    endtask

    task automatic junk_inputs();
        req_we    = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic [63:0] addr, input logic [63:0] wdata);
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat, n;
        model(we, size, addr, wdata, 1, exp_err, exp_rdata, exp_lat);
        @(negedge clk);
        check({tag, "/ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        junk_inputs();
        check({tag, "/busy"}, {busy, req_ready}, 2'b10);
        n = 1;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/lat"}, n, exp_lat);
        check({tag, "/err"}, rsp_err, exp_err);
        check({tag, "/rdata"}, rsp_rdata, exp_rdata);
        @(negedge clk);
        check({tag, "/pulse"}, rsp_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_dq [4];
        logic [63:0] addr;
        logic [1:0]  size;
        int          r, n, ce_before;

        exp_dq = '{16'h7788, 16'h5566, 16'h3344, 16'h1122};
        for (int i = 0; i < (1 << 20); i++) ref_mem[i] = 8'(i * 13 + 5);
        for (int w = 0; w < (1 << ADDR_W); w++) dev[w] = {ref_mem[2*w+1], ref_mem[2*w]};

        // 1: reset values
        rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0;
        junk_inputs();
        repeat (3) @(negedge clk);
        check("rst/strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, 5'b11111);
        check("rst/dq_z", sram_dq === 16'hzzzz, 1'b1);
        check("rst/rsp", {req_ready, rsp_valid, rsp_err, busy}, 4'b1000);
        check("rst/rdata", rsp_rdata, 64'd0);
        check("rst/addr", sram_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle/strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, 5'b11111);

        // 2: D store, beat order and latency
        beat_q.delete();
        do_req("d_store", 1'b1, 2'd3, BASE + 64'h10, 64'h1122334455667788);
        check("d_store/nbeats", beat_q.size(), 4);
        for (int k = 0; k < beat_q.size() && k < 4; k++) begin
            check($sformatf("d_store/addr%0d", k), beat_q[k].addr, 8 + k);
            check($sformatf("d_store/dq%0d", k), beat_q[k].dq, exp_dq[k]);
            check($sformatf("d_store/be%0d", k), beat_q[k].be_n, 2'b00);
        end

        // 3: byte store to the upper lane, then read it back
        beat_q.delete();
        do_req("b_store", 1'b1, 2'd0, BASE + 64'h3, 64'hAB);
        check("b_store/nbeats", beat_q.size(), 1);
        if (beat_q.size() > 0) begin
            check("b_store/addr", beat_q[0].addr, 1);
            check("b_store/be", beat_q[0].be_n, 2'b01);
            check("b_store/dq_hi", beat_q[0].dq[15:8], 8'hAB);
        end
        do_req("b_load", 1'b0, 2'd0, BASE + 64'h3, 64'd0);

        // 4/5: misaligned and out-of-range requests never touch the SRAM
        ce_before = ce_cycles;
        do_req("misalign", 1'b0, 2'd2, BASE + 64'h2, 64'd0);
        do_req("below", 1'b0, 2'd1, 64'h7FFF_FFFE, 64'd0);
        do_req("above", 1'b0, 2'd0, BASE + MEM_BYTES, 64'd0);
        check("err/no_ce", ce_cycles - ce_before, 0);
        do_req("last_d", 1'b0, 2'd3, BASE + MEM_BYTES - 64'd8, 64'd0);

        // 5: WAIT_CYC=3 instance, D store latency
        @(negedge clk);
        req_valid3 = 1'b1; req_we = 1'b1; req_size = 2'd3;
        req_addr = BASE + 64'h10; req_wdata = 64'h1122334455667788;
        @(negedge clk);
        req_valid3 = 1'b0;
        junk_inputs();
        n = 1;
        while (!rsp_valid3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait3/lat", n, 21);
        check("wait3/err", rsp_err3, 1'b0);

        // 6: reset in the second beat of a D store (same data as before)
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3;
        req_addr = BASE + 64'h10; req_wdata = 64'h1122334455667788;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(sram_addr == 9 && !sram_ce_n) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("rst_mid/in_beat2", {sram_addr, sram_we_n}, {19'd9, 1'b0});
        #2 rst = 1'b1;
        #1;
        check("rst_mid/strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, 5'b11111);
        check("rst_mid/dq_z", sram_dq === 16'hzzzz, 1'b1);
        check("rst_mid/idle", {req_ready, busy}, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        repeat (20) @(negedge clk);
        check("rst_mid/no_rsp", rsp_seen, 0);
        do_req("after_rst", 1'b0, 2'd2, BASE + 64'h10, 64'd0);

        // random traffic in a small window, with some bad addresses
        for (int t = 0; t < 80; t++) begin
            r    = $urandom_range(0, 9);
            size = 2'($urandom_range(0, 3));
            if (r == 0)      addr = BASE - 64'(8 * $urandom_range(1, 4));
            else if (r == 1) addr = BASE + MEM_BYTES + 64'(8 * $urandom_range(0, 4));
            else begin
                addr = BASE + 64'($urandom_range(0, 255));
                if (r >= 3) addr = addr & ~((64'd1 << size) - 64'd1);
            end
            do_req($sformatf("rnd%0d", t), 1'($urandom), size, addr, {$urandom, $urandom});
        end

        check("oe_we_overlap", overlap_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
